// File: rtl/multi_precision_packer.sv
// Packs full- or half-precision beats from per-chain firmware into an N-lane output vector,
// holding 2N half-width slots and emitting when full, on overflow, on eof flush or on drain.
module multi_precision_packer #(
  parameter int N                                   = 8,
  parameter int M                                   = 2,
  parameter int DATA_WIDTH                          = 32,
  parameter int MAX_CHAINS                          = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID          = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE      = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tracing,
  input  logic                          valid_in,
  output logic                          in_ready,
  input  logic [1:0]                    eof_in,
  input  logic [1:0]                    bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [$clog2(2*N):0]          fill_out
);

  localparam int H  = DATA_WIDTH / 2;
  localparam int S  = 2 * N;
  localparam int FW = $clog2(2 * N) + 1;
  localparam int EW = FW + 1;
  localparam int BW = N * DATA_WIDTH;
  localparam logic [EW-1:0] S_E = EW'(S);

  localparam logic [0:0] ST_FILL       = 1'b0;
  localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

  logic [BW-1:0] r_slots;
  logic [FW-1:0] r_fill;
  logic [0:0]    r_state;
  logic [BW-1:0] r_vec;
  logic          r_valid;
  logic [7:0]    r_byte_cnt;
  logic [7:0]    r_mode [MAX_CHAINS];
  logic [7:0]    r_cond [MAX_CHAINS];

  logic          w_out_free;
  logic          w_in_ready;
  logic [7:0]    w_mode;
  logic [7:0]    w_cond;
  logic          w_cond_ok;
  logic          w_consume;
  logic          w_pack;
  logic          w_half;
  logic          w_flush;
  logic [EW-1:0] w_k;
  logic [EW-1:0] w_need;
  logic [EW-1:0] w_aligned;
  logic [EW-1:0] w_end;
  logic [15:0]   w_shamt;
  logic [BW-1:0] w_data;
  logic [BW-1:0] w_shifted;
  logic [BW-1:0] w_nxt_slots;
  logic [FW-1:0] w_nxt_fill;
  logic [0:0]    w_nxt_state;
  logic          w_emit;
  logic [BW-1:0] w_emit_vec;

  assign w_out_free = !r_valid || ready_out;
  assign w_in_ready = w_out_free && (r_state == ST_FILL);
  assign w_mode     = r_mode[chainId_in];
  assign w_cond     = r_cond[chainId_in];
  // Each condition bit selects one polarity of one eof/bof flag; selected terms are ORed.
  assign w_cond_ok  = (w_cond == 8'd0) ||
                      (|(w_cond & {~bof_in[1], bof_in[1], ~eof_in[1], eof_in[1],
                                   ~bof_in[0], bof_in[0], ~eof_in[0], eof_in[0]}));
  assign w_consume  = valid_in && w_in_ready && tracing;
  assign w_pack     = w_consume && (w_mode[1:0] != 2'd3) && w_cond_ok;
  assign w_half     = w_mode[2];
  assign w_flush    = w_consume && w_mode[3] && eof_in[0];

  always_comb begin
    w_k = '0;
    case (w_mode[1:0])
      2'd0:    w_k = EW'(N);
      2'd1:    w_k = EW'(M);
      2'd2:    w_k = EW'(1);
      default: w_k = '0;
    endcase
  end

  assign w_need    = w_half ? w_k : (w_k << 1);
  assign w_aligned = EW'(r_fill) + EW'(!w_half && r_fill[0]);
  assign w_end     = w_aligned + w_need;
  assign w_shamt   = 16'(w_aligned) * 16'(H);

  // Beat elements laid out as contiguous half-slots starting at slot 0, zero beyond need.
  always_comb begin
    w_data = '0;
    for (int e = 0; e < N; e++) begin
      if (EW'(e) < w_k) begin
        if (w_half)
          w_data[e*H +: H] = vector_in[e*DATA_WIDTH +: H];
        else
          w_data[e*DATA_WIDTH +: DATA_WIDTH] = vector_in[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Slots at and above fill are always zero, so OR-ing in the shifted beat also zeroes any pad slot.
  assign w_shifted = w_data << w_shamt;

  always_comb begin
    w_nxt_slots = r_slots;
    w_nxt_fill  = r_fill;
    w_nxt_state = r_state;
    w_emit      = 1'b0;
    w_emit_vec  = r_slots;
    if (r_state == ST_FLUSH_PEND) begin
      if (w_out_free) begin
        w_emit      = 1'b1;
        w_emit_vec  = r_slots;
        w_nxt_slots = '0;
        w_nxt_fill  = '0;
        w_nxt_state = ST_FILL;
      end
    end else if (w_consume) begin
      if (w_pack) begin
        if (w_end < S_E) begin
          w_nxt_slots = r_slots | w_shifted;
          w_nxt_fill  = w_end[FW-1:0];
        end else if (w_end == S_E) begin
          w_emit      = 1'b1;
          w_emit_vec  = r_slots | w_shifted;
          w_nxt_slots = '0;
          w_nxt_fill  = '0;
        end else begin
          w_emit      = 1'b1;
          w_emit_vec  = r_slots;
          w_nxt_slots = w_data;
          w_nxt_fill  = w_need[FW-1:0];
        end
      end
      // An overflow emit already owns the output this cycle, so the remainder waits.
      if (w_flush && (w_nxt_fill != '0)) begin
        if (w_emit) begin
          w_nxt_state = ST_FLUSH_PEND;
        end else begin
          w_emit      = 1'b1;
          w_emit_vec  = w_nxt_slots;
          w_nxt_slots = '0;
          w_nxt_fill  = '0;
        end
      end
    end else if (!tracing && (r_fill != '0) && w_out_free) begin
      w_emit      = 1'b1;
      w_emit_vec  = r_slots;
      w_nxt_slots = '0;
      w_nxt_fill  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slots    <= '0;
      r_fill     <= '0;
      r_state    <= ST_FILL;
      r_vec      <= '0;
      r_valid    <= 1'b0;
      r_byte_cnt <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        r_mode[c] <= INITIAL_FIRMWARE[8*c +: 8];
        r_cond[c] <= INITIAL_FIRMWARE_COND[8*c +: 8];
      end
    end else begin
      r_slots <= w_nxt_slots;
      r_fill  <= w_nxt_fill;
      r_state <= w_nxt_state;
      if (w_emit) begin
        r_vec   <= w_emit_vec;
        r_valid <= 1'b1;
      end else if (ready_out) begin
        r_valid <= 1'b0;
      end
      // Config stream: cond bytes first, then mode bytes; the counter saturates so late bytes never wrap.
      if (configId != PERSONAL_CONFIG_ID) begin
        r_byte_cnt <= '0;
      end else if (!tracing) begin
        if (r_byte_cnt != 8'hFF)
          r_byte_cnt <= r_byte_cnt + 8'd1;
        for (int c = 0; c < MAX_CHAINS; c++) begin
          if (r_byte_cnt == 8'(c))
            r_cond[c] <= configData;
          if (r_byte_cnt == 8'(MAX_CHAINS + c))
            r_mode[c] <= configData;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign vector_out = r_vec;
  assign valid_out  = r_valid;
  assign fill_out   = r_fill;

endmodule

// File: tb/tb_multi_precision_packer.sv
// Bench for multi_precision_packer: slot-array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized firmware and traffic.
module tb_multi_precision_packer;

  logic         clk;
  logic         resetn;
  logic         tracing;
  logic         valid_in;
  logic         in_ready;
  logic [1:0]   eof_in;
  logic [1:0]   bof_in;
  logic [1:0]   chainId_in;
  logic [7:0]   configId;
  logic [7:0]   configData;
  logic [255:0] vector_in;
  logic [255:0] vector_out;
  logic         valid_out;
  logic         ready_out;
  logic [4:0]   fill_out;

  int n_checks = 0;
  int n_fail   = 0;

  multi_precision_packer dut (
    .clk(clk), .resetn(resetn), .tracing(tracing), .valid_in(valid_in),
    .in_ready(in_ready), .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .valid_out(valid_out), .ready_out(ready_out),
    .fill_out(fill_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 16 half-word slots, fill count, pending-flush flag, output register.
  logic [15:0] m_slots [16];
  logic [15:0] m_vec   [16];
  int          m_fill;
  bit          m_pend;
  bit          m_vld;
  logic [7:0]  m_mode [4];
  logic [7:0]  m_cond [4];
  int          m_cnt;

  task automatic model_clear();
    foreach (m_slots[i]) m_slots[i] = '0;
    m_fill = 0;
  endtask

  task automatic model_reset();
    model_clear();
    foreach (m_vec[i]) m_vec[i] = '0;
    m_pend = 0;
    m_vld  = 0;
    m_cnt  = 0;
    foreach (m_mode[i]) begin
      m_mode[i] = '0;
      m_cond[i] = '0;
    end
  endtask

  task automatic model_step();
    bit          free, rdy, emit, half, ok;
    logic [7:0]  md, cd;
    logic [31:0] lane;
    logic [15:0] ev [16];
    logic [15:0] d [$];
    int          k, a;
    free = !m_vld || ready_out;
    rdy  = free && !m_pend;
    emit = 0;
    foreach (ev[i]) ev[i] = '0;
    if (m_pend) begin
      if (free) begin
        emit = 1; ev = m_slots; model_clear(); m_pend = 0;
      end
    end else if (valid_in && rdy && tracing) begin
      md = m_mode[chainId_in];
      cd = m_cond[chainId_in];
      case (md[1:0])
        2'd0:    k = 8;
        2'd1:    k = 2;
        2'd2:    k = 1;
        default: k = 0;
      endcase
      half = md[2];
      ok = (cd == 8'd0) || (cd[0] && eof_in[0]) || (cd[1] && !eof_in[0]) ||
           (cd[2] && bof_in[0]) || (cd[3] && !bof_in[0]) || (cd[4] && eof_in[1]) ||
           (cd[5] && !eof_in[1]) || (cd[6] && bof_in[1]) || (cd[7] && !bof_in[1]);
      if (k > 0 && ok) begin
        for (int e = 0; e < k; e++) begin
          lane = vector_in[e*32 +: 32];
          d.push_back(lane[15:0]);
          if (!half) d.push_back(lane[31:16]);
        end
        a = m_fill;
        if (!half && (a % 2 == 1)) begin
          m_slots[a] = '0;
          a++;
        end
        if (a + d.size() > 16) begin
          emit = 1; ev = m_slots; model_clear(); a = 0;
        end
        foreach (d[j]) m_slots[a+j] = d[j];
        m_fill = a + d.size();
        if (m_fill == 16 && !emit) begin
          emit = 1; ev = m_slots; model_clear();
        end
      end
      if (md[3] && eof_in[0] && m_fill > 0) begin
        if (emit) m_pend = 1;
        else begin
          emit = 1; ev = m_slots; model_clear();
        end
      end
    end else if (!tracing && m_fill > 0 && free) begin
      emit = 1; ev = m_slots; model_clear();
    end
    if (configId != 8'h00) m_cnt = 0;
    else if (!tracing) begin
      if (m_cnt < 4) m_cond[m_cnt] = configData;
      else if (m_cnt < 8) m_mode[m_cnt-4] = configData;
      if (m_cnt < 255) m_cnt++;
    end
    if (emit) begin
      m_vld = 1; m_vec = ev;
    end else if (ready_out) m_vld = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    bit exp_rdy;
    exp_rdy = (!m_vld || ready_out) && !m_pend;
    chk("valid_out", 32'(valid_out), 32'(m_vld));
    chk("fill_out", 32'(fill_out), 32'(m_fill));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_vld)
      for (int i = 0; i < 8; i++)
        chk($sformatf("lane%0d", i), vector_out[i*32 +: 32], {m_vec[2*i+1], m_vec[2*i]});
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
  endtask

  function automatic logic [255:0] rnd_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cfg(input logic [31:0] conds, input logic [31:0] modes);
    tracing  = 1'b0;
    valid_in = 1'b0;
    configId = 8'hFF;
    tick();
    for (int b = 0; b < 8; b++) begin
      configId   = 8'h00;
      configData = (b < 4) ? conds[b*8 +: 8] : modes[(b-4)*8 +: 8];
      tick();
    end
    configId = 8'hFF;
    tracing  = 1'b1;
    tick();
  endtask

  task automatic send(input logic [1:0] ch, input logic [255:0] v, input logic e0);
    int w;
    chainId_in = ch;
    vector_in  = v;
    eof_in     = {1'b0, e0};
    bof_in     = 2'b00;
    valid_in   = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      #1;
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drain();
    tracing = 1'b0;
    tick();
    tracing = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v;
    logic [31:0]  conds, modes;

    resetn = 1'b0; tracing = 1'b1; valid_in = 1'b0; eof_in = '0; bof_in = '0;
    chainId_in = '0; configId = 8'hFF; configData = '0; vector_in = '0; ready_out = 1'b1;
    repeat (3) tick();
    chk("rst_fill", 32'(fill_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_vec_lane0", vector_out[31:0], 32'd0);
    resetn = 1'b1;
    #1;
    chk("rdy_after_reset", 32'(in_ready), 32'd1);

    // chain0 full x1, chain1 half xM, chain2 full xM, chain3 full xN
    cfg(32'h0, 32'h00_01_05_02);

    for (int n = 1; n <= 8; n++) begin
      v = rnd_vec();
      v[31:0] = 32'(n);
      send(2'd0, v, 1'b0);
      if (n == 7) chk("full1_fill14", 32'(fill_out), 32'd14);
    end
    chk("full1_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("full1_lane%0d", i), vector_out[i*32 +: 32], 32'(i + 1));

    for (int b = 0; b < 8; b++) begin
      v = rnd_vec();
      v[15:0]  = 16'(16'hA0 + 2*b);
      v[47:32] = 16'(16'hA0 + 2*b + 1);
      send(2'd1, v, 1'b0);
    end
    chk("halfM_valid", 32'(valid_out), 32'd1);
    chk("halfM_lane0", vector_out[31:0], 32'h00A1_00A0);
    chk("halfM_lane3", vector_out[127:96], 32'h00A7_00A6);
    chk("halfM_lane7", vector_out[255:224], 32'h00AF_00AE);

    for (int b = 0; b < 3; b++) begin
      v = rnd_vec();
      v[31:0]  = 32'h3500_0000 + 32'(2*b);
      v[63:32] = 32'h3500_0000 + 32'(2*b + 1);
      send(2'd2, v, 1'b0);
    end
    chk("fullM_fill12", 32'(fill_out), 32'd12);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'h4E00_0000 + 32'(i);
    send(2'd3, v, 1'b0);
    chk("ovf_fill16", 32'(fill_out), 32'd16);
    chk("ovf_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("ovf_lane%0d", i), vector_out[i*32 +: 32], 32'h3500_0000 + 32'(i));
    chk("ovf_lane6", vector_out[223:192], 32'd0);
    chk("ovf_lane7", vector_out[255:224], 32'd0);
    drain();
    chk("fullN_valid", 32'(valid_out), 32'd1);
    chk("fullN_fill0", 32'(fill_out), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("fullN_lane%0d", i), vector_out[i*32 +: 32], 32'h4E00_0000 + 32'(i));

    cfg(32'h0, 32'h00_01_06_02);
    v = rnd_vec(); v[15:0] = 16'h1234;
    send(2'd1, v, 1'b0);
    v = rnd_vec(); v[31:0] = 32'hDEADBEEF;
    send(2'd0, v, 1'b0);
    chk("pad_fill4", 32'(fill_out), 32'd4);
    drain();
    chk("pad_lane0", vector_out[31:0], 32'h0000_1234);
    chk("pad_lane1", vector_out[63:32], 32'hDEAD_BEEF);
    chk("pad_lane2", vector_out[95:64], 32'd0);

    tick();
    ready_out = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      v = rnd_vec(); v[31:0] = 32'h3700 + 32'(n);
      send(2'd0, v, 1'b0);
    end
    v = rnd_vec(); v[31:0] = 32'h37AA;
    chainId_in = 2'd0; vector_in = v; eof_in = '0; valid_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(valid_out), 32'd1);
      chk("hold_lane0", vector_out[31:0], 32'h3701);
      chk("hold_lane7", vector_out[255:224], 32'h3708);
    end
    ready_out = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    valid_in = 1'b0;
    chk("release_fill2", 32'(fill_out), 32'd2);
    chk("release_valid0", 32'(valid_out), 32'd0);
    drain();
    chk("held_beat_lane0", vector_out[31:0], 32'h37AA);
    chk("held_beat_lane1", vector_out[63:32], 32'd0);
    tick();

    for (int n = 0; n < 3; n++) send(2'd0, rnd_vec(), 1'b0);
    chk("pre_rst_fill6", 32'(fill_out), 32'd6);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_fill", 32'(fill_out), 32'd0);
    chk("async_rst_valid", 32'(valid_out), 32'd0);
    chk("async_rst_vec", vector_out[31:0], 32'd0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rdy_after_rst2", 32'(in_ready), 32'd1);
    tick();
    chk("no_partial_emit", 32'(valid_out), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        conds[c*8 +: 8] = ($urandom % 2 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        modes[c*8 +: 8] = 8'($urandom_range(0, 15));
      end
      if (r == 0) modes = modes | 32'h0000_0808;
      cfg(conds, modes);
      for (int cyc = 0; cyc < 1200; cyc++) begin
        tick();
        valid_in   = ($urandom % 4) != 0;
        tracing    = ($urandom % 16) != 0;
        ready_out  = ($urandom % 4) != 0;
        eof_in     = 2'($urandom);
        bof_in     = 2'($urandom);
        chainId_in = 2'($urandom);
        vector_in  = rnd_vec();
        configId   = 8'hFF;
      end
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    tracing   = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_precision_packer.md
MULTI_PRECISION_PACKER -- requirements
Module: multi_precision_packer

Interface
REQ-001 SHALL have parameter N, default 8: number of output lanes.
REQ-002 SHALL have parameter M, default 2: medium block length, 1<M<=N.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: lane width, even.
REQ-004 SHALL have parameter MAX_CHAINS, default 4: number of firmware chains.
REQ-005 SHALL have parameter PERSONAL_CONFIG_ID, default 0: configId that addresses this block.
REQ-006 SHALL have parameters INITIAL_FIRMWARE and INITIAL_FIRMWARE_COND, default all 0: per-chain mode and condition bytes, [7:0] x MAX_CHAINS.
REQ-007 SHALL have ports: clk in 1, the single clock; resetn in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: tracing in 1; valid_in in 1; in_ready out 1; eof_in in 2; bof_in in 2; chainId_in in clog2(MAX_CHAINS); configId in 8; configData in 8.
REQ-009 SHALL have ports: vector_in in DATA_WIDTH x N; vector_out out DATA_WIDTH x N; valid_out out 1; ready_out in 1; fill_out out clog2(2N)+1 (occupied half-slots).

Function
REQ-010 SHALL model storage as 2N half-width slots; output lane i = {slot[2i+1], slot[2i]}.
REQ-011 Mode byte per chain SHALL decode as: [1:0] length 0=N, 1=M, 2=1, 3=disabled (no commit); [2] precision 0=full, 1=half; [3] flush_on_eof.
REQ-012 Condition byte SHALL gate beats exactly as: 0 = always; bits 0..7 = eof[0]=1, eof[0]=0, bof[0]=1, bof[0]=0, eof[1]=1, eof[1]=0, bof[1]=1, bof[1]=0, ORed.
REQ-013 in_ready SHALL be 1 when (!valid_out || ready_out) and state is FILL; it does not depend on valid_in.
REQ-014 A beat SHALL be consumed when valid_in && in_ready && tracing; it SHALL be packed only if commit && cond_valid, otherwise dropped.
REQ-015 A packed beat of k elements SHALL need k slots (half: element[DATA_WIDTH/2-1:0]) or 2k slots (full: low half then high half).
REQ-016 A full-precision beat with odd fill SHALL first zero one pad slot (aligned fill = fill+1).
REQ-017 If aligned fill + need < 2N, data SHALL append at aligned fill, with no output.
REQ-018 If aligned fill + need = 2N, the buffer plus data SHALL load vector_out next cycle with valid_out=1, and fill SHALL return to 0.
REQ-019 If aligned fill + need > 2N, the current buffer (unfilled slots zero) SHALL be emitted, data SHALL move to slot 0, and fill SHALL become need.
REQ-020 Latency: accept edge -> valid_out high after the same edge (one register stage).
REQ-021 vector_out and valid_out SHALL hold stable while valid_out && !ready_out.
REQ-022 Flush: on an accepted beat with flush_on_eof and eof_in[0]=1, if post-append fill>0, the remainder SHALL be emitted zero-padded.
REQ-023 If the flush coincides with the emit of REQ-019, state SHALL go to FLUSH_PEND; in FLUSH_PEND, in_ready=0, the remainder is emitted when the output is free, then state returns to FILL.
REQ-024 Drain: when tracing=0, fill>0 and output free, the partial buffer SHALL be emitted zero-padded and fill cleared.
REQ-025 Config: while tracing=0 and configId==PERSONAL_CONFIG_ID, byte_counter SHALL increment each cycle.
REQ-026 During config, bytes 0..MAX_CHAINS-1 SHALL write the cond bytes and bytes MAX_CHAINS..2*MAX_CHAINS-1 SHALL write the mode bytes; later bytes SHALL be ignored.
REQ-027 byte_counter SHALL clear when configId differs from PERSONAL_CONFIG_ID.
REQ-028 Drain and config SHALL proceed in the same cycles.
REQ-029 fill_out SHALL equal the registered fill.

Reset
REQ-030 On resetn=0, immediately: valid_out=0, vector_out=0, all slots=0, fill=0, state=FILL, byte_counter=0, firmware arrays = INITIAL values.
REQ-031 Reset mid-packing SHALL discard partial data with no emission.
REQ-032 After resetn rises, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-033 Full precision, length 1, values 1..8 on 8 beats, ready_out=1 -> one valid_out pulse, lanes 0..7 = 1..8.
REQ-034 Half precision, length M, 8 beats with element values 16'hA0+n (n=0..15) -> one output, lane i = {A0+2i+1, A0+2i}.
REQ-035 Full M x3 (fill 12), then full N beat -> emit lanes 0..5 data, lanes 6..7 = 0; fill_out=16 then output of the N beat.
REQ-036 Half length-1 beat 0x1234, then full length-1 beat 0xDEADBEEF -> fill_out=4; lane0=0x00001234, lane1=0xDEADBEEF.
REQ-037 ready_out=0 for 5 cycles while valid_out=1 -> in_ready=0 and vector_out stable; the held beat is accepted after release, with no loss or duplicate.
REQ-038 resetn pulse low asynchronously with fill_out=6 -> fill_out=0, valid_out=0 before next edge; no partial emitted.
